uart_rx_ctrl: RTL

//  Receive-side controller behind the UART receiver. Captures each received byte on the

---
 rtl/uart_rx_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller behind a UART receiver.
// Captures one byte per rising edge of rxDone into a show-ahead FIFO,
// drives RTS with hysteresis, keeps sticky overrun/frame-error flags and,
// when UART_RX_CTRL_IDLE_EN is defined, pulses idle after IdleCycles quiet cycles.
module uart_rx_ctrl #(
  parameter int Depth      = 8,
  parameter int RtsHigh    = Depth - 2,
  parameter int RtsLow     = Depth / 2,
  parameter int IdleCycles = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output logic [7:0]             rdData,
  output logic                   rdValid,
  input  logic                   rdReady,
  output logic [$clog2(Depth):0] count,
  output logic                   rts,
  output logic                   overrun,
  output logic                   frameErr,
  input  logic                   errClr,
  output logic                   idle
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [Depth];
  logic [7:0]    mem_d [Depth];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          rts_q, rts_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;

  logic acc;
  logic pop;
  logic full;
  logic drop;
  logic wr_en;

  assign rdValid  = (count_q != '0);
  assign rdData   = rdValid ? mem_q[rd_ptr_q] : 8'h00;
  assign count    = count_q;
  assign rts      = rts_q;
  assign overrun  = overrun_q;
  assign frameErr = frame_err_q;

  // Edge-detect rxDone, arbitrate push/pop/drop and compute next FIFO, RTS and flag state
  always_comb begin
    acc   = rxDone && !done_q;
    full  = (count_q == CW'(Depth));
    pop   = rdValid && rdReady;
    drop  = acc && full && !pop;
    wr_en = acc && !drop;

    done_d   = rxDone;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = rxData;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(wr_en) - CW'(pop);

    rts_d = rts_q;
    if (count_d >= CW'(RtsHigh)) begin
      rts_d = 1'b0;
    end else if (count_d <= CW'(RtsLow)) begin
      rts_d = 1'b1;
    end

    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (errClr) begin
      overrun_d = 1'b0;
    end

    frame_err_d = frame_err_q;
    if (rxErr) begin
      frame_err_d = 1'b1;
    end else if (errClr) begin
      frame_err_d = 1'b0;
    end
  end

  // Register FIFO storage, pointers, occupancy, RTS and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q       <= '{default: 8'h00};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b1;
      rts_q       <= 1'b1;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      done_q      <= done_d;
      rts_q       <= rts_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef UART_RX_CTRL_IDLE_EN
  localparam int IW = $clog2(IdleCycles);

  typedef enum logic {
    S_WAIT,
    S_ACTIVE
  } idle_state_e;

  idle_state_e   state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          idle_hit;

  assign idle_hit = (state_q == S_ACTIVE) && !acc && (idle_cnt_q == IW'(IdleCycles - 1));

  // Idle state and quiet-cycle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_WAIT;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next idle state: any accepted byte (re)arms the counter, expiry returns to waiting
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      S_WAIT: begin
        if (acc) begin
          state_d    = S_ACTIVE;
          idle_cnt_d = '0;
        end
      end
      S_ACTIVE: begin
        if (acc) begin
          idle_cnt_d = '0;
        end else if (idle_hit) begin
          state_d    = S_WAIT;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      default: begin
        state_d    = S_WAIT;
        idle_cnt_d = '0;
      end
    endcase
  end

  // Single-cycle idle pulse on expiry, suppressed by a same-cycle accept
  always_comb begin
    idle = 1'b0;
    if (idle_hit) begin
      idle = 1'b1;
    end
  end
`else
  assign idle = 1'b0;
`endif

endmodule
